sne_apb_cfg_slave: RTL and testbench

SNE_APB_CFG_SLAVE -- requirements
Module: sne_apb_cfg_slave

---
 rtl/sne_apb_cfg_pkg.sv | 30 +++
 rtl/sne_apb_cfg_decode.sv | 47 ++++
 rtl/sne_apb_cfg_slave.sv | 185 ++++++++++++++++++
 tb/tb_sne_apb_cfg_slave.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sne_apb_cfg_pkg.sv
// Shared definitions for the APB configuration slave: register map offsets,
// command/error bit positions, FSM states and decoded register kinds.
package sne_apb_cfg_pkg;

    localparam int MAX_REGS = 16;

    localparam logic [7:0] OFF_STATUS = 8'h40;
    localparam logic [7:0] OFF_CMD    = 8'h44;
    localparam logic [7:0] OFF_ERR    = 8'h48;

    localparam int CMD_START_BIT   = 0;
    localparam int CMD_CLR_ERR_BIT = 1;
    localparam int ERR_DECODE_BIT  = 0;
    localparam int ERR_BUSY_BIT    = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } apb_state_e;

    typedef enum logic [2:0] {
        REG_CFG    = 3'd0,
        REG_STATUS = 3'd1,
        REG_CMD    = 3'd2,
        REG_ERR    = 3'd3,
        REG_NONE   = 3'd4
    } reg_kind_e;

endpackage

// File: rtl/sne_apb_cfg_decode.sv
// Combinational decode of the low address byte into register kind, CFG index
// and valid/read-only flags. Misaligned offsets never decode.
module sne_apb_cfg_decode
    import sne_apb_cfg_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [7:0] offset_i,
    output reg_kind_e  kind_o,
    output logic [3:0] index_o,
    output logic       valid_o,
    output logic       readonly_o
);

    // Map offset to register kind
    always_comb begin
        kind_o     = REG_NONE;
        index_o    = offset_i[5:2];
        valid_o    = 1'b0;
        readonly_o = 1'b0;
        if (offset_i[1:0] != 2'b00) begin
            kind_o = REG_NONE;
        end else if ({26'd0, offset_i[7:2]} < 32'(NUM_REGS)) begin
            kind_o  = REG_CFG;
            valid_o = 1'b1;
        end else begin
            case (offset_i)
                OFF_STATUS: begin
                    kind_o     = REG_STATUS;
                    valid_o    = 1'b1;
                    readonly_o = 1'b1;
                end
                OFF_CMD: begin
                    kind_o  = REG_CMD;
                    valid_o = 1'b1;
                end
                OFF_ERR: begin
                    kind_o     = REG_ERR;
                    valid_o    = 1'b1;
                    readonly_o = 1'b1;
                end
                default: kind_o = REG_NONE;
            endcase
        end
    end

endmodule

// File: rtl/sne_apb_cfg_slave.sv
// APB configuration slave: zero-wait writes, reads delayed by READ_WAIT cycles
// in RD_WAIT, sticky error register and a one-cycle start pulse.
module sne_apb_cfg_slave
    import sne_apb_cfg_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int READ_WAIT = 1
) (
    input  logic                     system_clk_i,
    input  logic                     system_rst_ni,
    input  logic                     apb_slave_psel,
    input  logic                     apb_slave_penable,
    input  logic                     apb_slave_pwrite,
    input  logic [31:0]              apb_slave_paddr,
    input  logic [31:0]              apb_slave_pwdata,
    output logic [31:0]              apb_slave_prdata,
    output logic                     apb_slave_pready,
    output logic                     apb_slave_pslverr,
    output logic [NUM_REGS-1:0][31:0] cfg_o,
    output logic                     start_o,
    input  logic                     busy_i,
    input  logic [31:0]              status_i
);

    localparam logic [2:0] WAIT_INIT = 3'(READ_WAIT - 1);

    apb_state_e                state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [31:0]               prdata_q, prdata_d;
    logic                      rd_err_q, rd_err_d;
    logic [NUM_REGS-1:0][31:0] cfg_q, cfg_d;
    logic [1:0]                err_q, err_d;
    logic                      start_q, start_d;

    reg_kind_e   dec_kind_s;
    logic [3:0]  dec_index_s;
    logic        dec_valid_s;
    logic        dec_readonly_s;
    logic        wr_acc_s, rd_acc_s, wr_err_s, err_clr_s, rd_pready_s, rd_seterr_s;
    logic [1:0]  err_set_s;
    logic [31:0] rd_data_s;
    logic        unused_addr_s;

    assign unused_addr_s = ^apb_slave_paddr[31:8];

    sne_apb_cfg_decode #(.NUM_REGS(NUM_REGS)) u_decode (
        .offset_i   (apb_slave_paddr[7:0]),
        .kind_o     (dec_kind_s),
        .index_o    (dec_index_s),
        .valid_o    (dec_valid_s),
        .readonly_o (dec_readonly_s)
    );

    assign wr_acc_s = apb_slave_psel & apb_slave_penable & apb_slave_pwrite & (state_q == ST_IDLE);
    assign rd_acc_s = apb_slave_psel & apb_slave_penable & ~apb_slave_pwrite & (state_q == ST_IDLE);

    // Write side effects: CFG update, command decode and error detection
    always_comb begin
        cfg_d     = cfg_q;
        wr_err_s  = 1'b0;
        err_set_s = 2'b00;
        err_clr_s = 1'b0;
        start_d   = 1'b0;
        if (!wr_acc_s) begin
            cfg_d = cfg_q;
        end else if (!dec_valid_s) begin
            wr_err_s                  = 1'b1;
            err_set_s[ERR_DECODE_BIT] = 1'b1;
        end else if (dec_readonly_s) begin
            wr_err_s = 1'b1;
        end else begin
            case (dec_kind_s)
                REG_CFG: begin
                    if (busy_i) begin
                        wr_err_s                = 1'b1;
                        err_set_s[ERR_BUSY_BIT] = 1'b1;
                    end else begin
                        cfg_d[dec_index_s] = apb_slave_pwdata;
                    end
                end
                REG_CMD: begin
                    err_clr_s = apb_slave_pwdata[CMD_CLR_ERR_BIT];
                    if (apb_slave_pwdata[CMD_START_BIT] && busy_i) begin
                        wr_err_s                = 1'b1;
                        err_set_s[ERR_BUSY_BIT] = 1'b1;
                    end else begin
                        start_d = apb_slave_pwdata[CMD_START_BIT];
                    end
                end
                default: wr_err_s = 1'b1;
            endcase
        end
    end

    // Read data mux, sampled when the read is accepted
    always_comb begin
        case (dec_kind_s)
            REG_CFG:    rd_data_s = cfg_q[dec_index_s];
            REG_STATUS: rd_data_s = status_i;
            REG_ERR:    rd_data_s = {30'd0, err_q};
            REG_CMD:    rd_data_s = 32'd0;
            default:    rd_data_s = 32'd0;
        endcase
    end

    // Read FSM; an aborted read (psel dropped) leaves the error register alone
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prdata_d    = prdata_q;
        rd_err_d    = rd_err_q;
        rd_pready_s = 1'b0;
        rd_seterr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_acc_s) begin
                    prdata_d = rd_data_s;
                    rd_err_d = ~dec_valid_s;
                    cnt_d    = WAIT_INIT;
                    state_d  = ST_RD_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (!apb_slave_psel) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == 3'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (apb_slave_psel) begin
                    rd_pready_s = 1'b1;
                    rd_seterr_s = rd_err_q;
                end else begin
                    rd_pready_s = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear first so that an error raised in the same cycle survives
    always_comb begin
        err_d = (err_clr_s ? 2'b00 : err_q) | err_set_s;
        if (rd_seterr_s) begin
            err_d[ERR_DECODE_BIT] = 1'b1;
        end else begin
            err_d[ERR_DECODE_BIT] = err_d[ERR_DECODE_BIT];
        end
    end

    // State registers
    always_ff @(posedge system_clk_i or negedge system_rst_ni) begin
        if (!system_rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            prdata_q <= 32'd0;
            rd_err_q <= 1'b0;
            cfg_q    <= {NUM_REGS{32'd0}};
            err_q    <= 2'b00;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prdata_q <= prdata_d;
            rd_err_q <= rd_err_d;
            cfg_q    <= cfg_d;
            err_q    <= err_d;
            start_q  <= start_d;
        end
    end

    assign apb_slave_pready  = system_rst_ni & (wr_acc_s | rd_pready_s);
    assign apb_slave_pslverr = system_rst_ni & ((wr_acc_s & wr_err_s) | (rd_pready_s & rd_err_q));
    assign apb_slave_prdata  = prdata_q;
    assign cfg_o             = cfg_q;
    assign start_o           = start_q;

endmodule

// File: tb/tb_sne_apb_cfg_slave.sv
// Randomized bench for sne_apb_cfg_slave against an address-map level model.
module tb_sne_apb_cfg_slave;

    localparam int NR = 16;
    localparam int RW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              psel, penable, pwrite;
    logic [31:0]       paddr, pwdata, prdata, status;
    logic              pready, pslverr, start, busy;
    logic [NR-1:0][31:0] cfg;

    logic [31:0] m_cfg [NR];
    logic [1:0]  m_err;
    int          n_checks = 0;
    int          n_errors = 0;

    sne_apb_cfg_slave #(.NUM_REGS(NR), .READ_WAIT(RW)) dut (
        .system_clk_i      (clk),
        .system_rst_ni     (rst_n),
        .apb_slave_psel    (psel),
        .apb_slave_penable (penable),
        .apb_slave_pwrite  (pwrite),
        .apb_slave_paddr   (paddr),
        .apb_slave_pwdata  (pwdata),
        .apb_slave_prdata  (prdata),
        .apb_slave_pready  (pready),
        .apb_slave_pslverr (pslverr),
        .cfg_o             (cfg),
        .start_o           (start),
        .busy_i            (busy),
        .status_i          (status)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_cfg[i] = 32'd0;
        m_err = 2'b00;
    endtask

    task automatic check_cfg(input string tag);
        for (int i = 0; i < NR; i++) check_value({tag, "_cfg"}, cfg[i], m_cfg[i]);
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic bsy,
                               output logic exp_e, output logic exp_s);
        int off;
        off   = int'(addr[7:0]);
        exp_e = 1'b0;
        exp_s = 1'b0;
        if ((off % 4) != 0) begin
            exp_e = 1'b1; m_err[0] = 1'b1;
        end else if (off < 4 * NR) begin
            if (bsy) begin exp_e = 1'b1; m_err[1] = 1'b1; end
            else m_cfg[off / 4] = data;
        end else if (off == 'h44) begin
            if (data[1]) m_err = 2'b00;
            if (data[0]) begin
                if (bsy) begin exp_e = 1'b1; m_err[1] = 1'b1; end
                else exp_s = 1'b1;
            end
        end else if (off == 'h40 || off == 'h48) begin
            exp_e = 1'b1;
        end else begin
            exp_e = 1'b1; m_err[0] = 1'b1;
        end
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] exp_d, output logic exp_e);
        int off;
        off   = int'(addr[7:0]);
        exp_d = 32'd0;
        exp_e = 1'b0;
        if ((off % 4) != 0) exp_e = 1'b1;
        else if (off < 4 * NR) exp_d = m_cfg[off / 4];
        else if (off == 'h40) exp_d = status;
        else if (off == 'h48) exp_d = {30'd0, m_err};
        else if (off == 'h44) exp_d = 32'd0;
        else exp_e = 1'b1;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic bsy, input string tag);
        logic exp_e, exp_s;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data; busy = bsy;
        model_write(addr, data, bsy, exp_e, exp_s);
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check_value({tag, "_pready"}, 32'(pready), 32'd1);
        check_value({tag, "_pslverr"}, 32'(pslverr), 32'(exp_e));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check_value({tag, "_start"}, 32'(start), 32'(exp_s));
        check_cfg(tag);
        @(negedge clk);
        check_value({tag, "_start_end"}, 32'(start), 32'd0);
    endtask

    task automatic apb_read(input logic [31:0] addr, input string tag);
        logic [31:0] exp_d;
        logic        exp_e, early;
        int          n;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        model_read(addr, exp_d, exp_e);
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        early = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            if (pready) break;
            if (pslverr) early = 1'b1;
            n++;
        end
        // access cycle plus RW wait cycles, response in the following one
        check_value({tag, "_latency"}, 32'(n), 32'(RW + 1));
        check_value({tag, "_prdata"}, prdata, exp_d);
        check_value({tag, "_pslverr"}, 32'(pslverr), 32'(exp_e));
        check_value({tag, "_early_err"}, 32'(early), 32'd0);
        if (exp_e) m_err[0] = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check_value({tag, "_hold"}, prdata, exp_d);
        check_value({tag, "_idle_rdy"}, 32'(pready), 32'd0);
    endtask

    initial begin
        logic [31:0] addr, data;
        logic        any_pr;
        int          sel, off;

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0; busy = 1'b0; status = 32'hA5A5_0001;
        model_reset();
        repeat (2) @(negedge clk);
        check_value("rst_prdata", prdata, 32'd0);
        check_value("rst_pready", 32'(pready), 32'd0);
        check_value("rst_pslverr", 32'(pslverr), 32'd0);
        check_value("rst_start", 32'(start), 32'd0);
        check_cfg("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        apb_write(32'h0000_0004, 32'hDEAD_BEEF, 1'b0, "w04");
        apb_read(32'h0000_0004, "r04");
        apb_write(32'h0000_0000, 32'h0000_0001, 1'b1, "wbusy");
        apb_read(32'h0000_0048, "err_busy");
        check_value("err_is_2", prdata, 32'h0000_0002);
        apb_write(32'h0000_0044, 32'h0000_0001, 1'b0, "start");
        apb_write(32'h0000_0044, 32'h0000_0001, 1'b1, "start_busy");
        apb_write(32'h0000_0044, 32'h0000_0002, 1'b0, "clr0");
        apb_read(32'h0000_0080, "r80");
        apb_read(32'h0000_0002, "r02");
        apb_read(32'h0000_0048, "err_dec");
        check_value("err_bit0", 32'(prdata[0]), 32'd1);
        apb_write(32'h0000_0044, 32'h0000_0002, 1'b0, "clr1");
        apb_read(32'h0000_0048, "err_clr");
        apb_read(32'h0000_0044, "rcmd");
        apb_write(32'h0000_0040, 32'h1234_5678, 1'b0, "wstat");
        apb_write(32'h0000_0048, 32'h0000_0003, 1'b0, "werr");
        apb_write(32'h0000_0044, 32'h0000_0003, 1'b1, "setwins");
        apb_read(32'h0000_0048, "err_setwins");
        apb_read(32'hFFFF_FF40, "rstat_hi");

        // psel dropped during RD_WAIT: no response, no error recorded
        @(posedge clk); #1;
        busy = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0080;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        any_pr = 1'b0;
        repeat (RW + 3) begin
            @(negedge clk);
            if (pready || pslverr) any_pr = 1'b1;
        end
        check_value("abort_no_rdy", 32'(any_pr), 32'd0);
        apb_read(32'h0000_0048, "err_after_abort");

        // reset asserted in RD_WAIT
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0004;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        psel = 1'b0; penable = 1'b0;
        model_reset();
        check_value("arst_pready", 32'(pready), 32'd0);
        check_value("arst_pslverr", 32'(pslverr), 32'd0);
        check_value("arst_prdata", prdata, 32'd0);
        check_value("arst_start", 32'(start), 32'd0);
        check_cfg("arst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        apb_read(32'h0000_0004, "r04_after_rst");
        apb_read(32'h0000_0048, "err_after_rst");

        for (int t = 0; t < 150; t++) begin
            status = $urandom;
            data   = $urandom;
            sel    = $urandom_range(9);
            case (sel)
                0, 1, 2, 3: off = 4 * $urandom_range(NR - 1);
                4:          off = 'h40;
                5:          off = 'h44;
                6:          off = 'h48;
                7:          off = 'h4C + 4 * $urandom_range(44);
                default:    off = 4 * $urandom_range(63) + $urandom_range(3, 1);
            endcase
            addr = ($urandom & 32'hFFFF_FF00) | 32'(off);
            if ($urandom_range(1) == 1) begin
                apb_write(addr, data, ($urandom_range(3) == 0), "rnd_wr");
            end else begin
                apb_read(addr, "rnd_rd");
            end
        end
        apb_read(32'h0000_0048, "rnd_err_final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
